// File: rtl/aes_sbox_gf24.sv
// AES forward S-box (SubBytes) for one byte, built on a composite-field GF((2^4)^2) inverter.
// Latency: out is combinational (0 cycles); out_q/out_q_valid are registered (1 cycle).
// Backpressure: none; a new byte is accepted every cycle and in_valid is carried alongside.
//
// Ports:
//   clk          rising-edge clock for the output register
//   rst_n        asynchronous active-low reset; clears out_q and out_q_valid
//   in           byte to substitute
//   in_valid     qualifies in for the registered path
//   out          combinational S(in)
//   out_q        S(in) captured at the last rising clk edge
//   out_q_valid  in_valid captured at the last rising clk edge
//
// Field choices: GF(2^4) uses x^4+x+1.  GF((2^4)^2) elements are h*Y+l with
// Y^2 = Y + lambda, lambda = 0xC.  The isomorphism sends the AES generator x
// to beta = 0x23 (h=2, l=3), which is a root of x^8+x^4+x^3+x+1 in this field.

module aes_sbox_gf24 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in,
    input  logic       in_valid,
    output logic [7:0] out,
    output logic [7:0] out_q,
    output logic       out_q_valid
);

    // ------------------------------------------------------------------
    // GF(2^4) arithmetic, field polynomial x^4 + x + 1
    // ------------------------------------------------------------------

    // Carry-less product followed by reduction with x^4=x+1, x^5=x^2+x, x^6=x^3+x^2.
    function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
        logic [6:0] p;
        logic [3:0] r;
        p = '0;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) begin
                p = p ^ ({3'b000, a} << i);
            end
        end
        r[0] = p[0] ^ p[4];
        r[1] = p[1] ^ p[4] ^ p[5];
        r[2] = p[2] ^ p[5] ^ p[6];
        r[3] = p[3] ^ p[6];
        return r;
    endfunction

    // Squaring is linear over GF(2): a0 + a1*x^2 + a2*(x+1) + a3*(x^3+x^2).
    function automatic logic [3:0] gf4_sq(input logic [3:0] a);
        logic [3:0] r;
        r[0] = a[0] ^ a[2];
        r[1] = a[2];
        r[2] = a[1] ^ a[3];
        r[3] = a[3];
        return r;
    endfunction

    // Multiply by the constant lambda = 0xC = x^3 + x^2 (sum of a*x^2 and a*x^3).
    function automatic logic [3:0] gf4_mul_lambda(input logic [3:0] a);
        logic [3:0] r;
        r[0] = a[1] ^ a[2];
        r[1] = a[1] ^ a[3];
        r[2] = a[0] ^ a[2];
        r[3] = a[0] ^ a[1] ^ a[3];
        return r;
    endfunction

    // Multiplicative inverse; 0 maps to 0 so that S(0x00) falls out as 0x63.
    function automatic logic [3:0] gf4_inv(input logic [3:0] a);
        logic [3:0] r;
        r = 4'h0;
        case (a)
            4'h1:    r = 4'h1;
            4'h2:    r = 4'h9;
            4'h3:    r = 4'hE;
            4'h4:    r = 4'hD;
            4'h5:    r = 4'hB;
            4'h6:    r = 4'h7;
            4'h7:    r = 4'h6;
            4'h8:    r = 4'hF;
            4'h9:    r = 4'h2;
            4'hA:    r = 4'hC;
            4'hB:    r = 4'h5;
            4'hC:    r = 4'hA;
            4'hD:    r = 4'h4;
            4'hE:    r = 4'h3;
            4'hF:    r = 4'h8;
            default: r = 4'h0;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Basis changes between GF(2^8) and GF((2^4)^2)
    // ------------------------------------------------------------------

    // delta: column i is beta^i written as {h, l}.
    function automatic logic [7:0] map_delta(input logic [7:0] a);
        return ({8{a[0]}} & 8'h01) ^ ({8{a[1]}} & 8'h23) ^
               ({8{a[2]}} & 8'h40) ^ ({8{a[3]}} & 8'h4A) ^
               ({8{a[4]}} & 8'h37) ^ ({8{a[5]}} & 8'hD7) ^
               ({8{a[6]}} & 8'h3F) ^ ({8{a[7]}} & 8'hEC);
    endfunction

    // delta^-1: column j is the AES-field byte whose image is composite bit j.
    function automatic logic [7:0] map_delta_inv(input logic [7:0] q);
        return ({8{q[0]}} & 8'h01) ^ ({8{q[1]}} & 8'h5C) ^
               ({8{q[2]}} & 8'hE0) ^ ({8{q[3]}} & 8'h50) ^
               ({8{q[4]}} & 8'hF2) ^ ({8{q[5]}} & 8'h5F) ^
               ({8{q[6]}} & 8'h04) ^ ({8{q[7]}} & 8'h6B);
    endfunction

    // b'_i = b_i ^ b_(i+4) ^ b_(i+5) ^ b_(i+6) ^ b_(i+7) ^ c_i; the terms
    // b_(i+7), b_(i+6), b_(i+5), b_(i+4) are left-rotations of b by 1..4.
    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^
               {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    logic [7:0] mapped;
    logic [3:0] hi;
    logic [3:0] lo;
    logic [3:0] hi_lo_sum;
    logic [3:0] norm;
    logic [3:0] norm_inv;
    logic [3:0] hi_inv;
    logic [3:0] lo_inv;
    logic [7:0] inv_byte;
    logic [7:0] sbox_val;

    assign mapped    = map_delta(in);
    assign hi        = mapped[7:4];
    assign lo        = mapped[3:0];
    assign hi_lo_sum = hi ^ lo;

    // Norm of h*Y+l: (h+l)*l + lambda*h^2.  Inverse is (h*Y + (h+l)) / norm.
    assign norm      = gf4_mul(hi_lo_sum, lo) ^ gf4_mul_lambda(gf4_sq(hi));
    assign norm_inv  = gf4_inv(norm);
    assign hi_inv    = gf4_mul(hi, norm_inv);
    assign lo_inv    = gf4_mul(hi_lo_sum, norm_inv);

    assign inv_byte  = map_delta_inv({hi_inv, lo_inv});
    assign sbox_val  = affine(inv_byte);

    assign out       = sbox_val;

    // ------------------------------------------------------------------
    // Output register: captures every cycle, valid travels alongside.
    // ------------------------------------------------------------------
    logic [7:0] sbox_d;
    logic [7:0] sbox_q;
    logic       vld_d;
    logic       vld_q;

    always_comb begin
        sbox_d = sbox_val;
        vld_d  = in_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sbox_q <= 8'h00;
            vld_q  <= 1'b0;
        end else begin
            sbox_q <= sbox_d;
            vld_q  <= vld_d;
        end
    end

    assign out_q       = sbox_q;
    assign out_q_valid = vld_q;

endmodule

// File: tb/tb_aes_sbox_gf24.sv
// Self-checking bench for aes_sbox_gf24.
// Reference S-box: GF(2^8) inverse as a^254 by repeated multiplication, then the affine map.
// Covers reset state, exhaustive sweep, spot table, latency, async reset, streaming.

module tb_aes_sbox_gf24;

    logic       clk;
    logic       rst_n;
    logic [7:0] din;
    logic       din_valid;
    logic [7:0] dout;
    logic [7:0] dout_q;
    logic       dout_q_valid;

    int n_vec;
    int n_err;

    aes_sbox_gf24 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in          (din),
        .in_valid    (din_valid),
        .out         (dout),
        .out_q       (dout_q),
        .out_q_valid (dout_q_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        logic       carry;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            carry = aa[7];
            aa    = aa << 1;
            if (carry) aa = aa ^ 8'h1B;
            bb    = bb >> 1;
        end
        return p;
    endfunction

    // a^254 = a^-1 for nonzero a, and 0 for a = 0.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < 254; i++) r = gmul(r, a);
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int k);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[(i + k) % 8] = b[i];
        return r;
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] din;
        logic [7:0] exp;
    } vec_t;

    vec_t spot[10];

    initial begin
        logic [7:0] cur;
        logic       cur_v;

        spot[0] = '{8'h00, 8'h63};
        spot[1] = '{8'h01, 8'h7C};
        spot[2] = '{8'h10, 8'hCA};
        spot[3] = '{8'h52, 8'h00};
        spot[4] = '{8'h53, 8'hED};
        spot[5] = '{8'h63, 8'hFB};
        spot[6] = '{8'hC9, 8'hDD};
        spot[7] = '{8'hFF, 8'h16};
        spot[8] = '{8'h02, 8'h77};
        spot[9] = '{8'h80, 8'hCD};

        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b1;
        din       = 8'h00;
        din_valid = 1'b0;

        // Reset state, reached without any clock edge.
        #1 rst_n = 1'b0;
        #1;
        check("reset_out_q", dout_q, 8'h00);
        check("reset_out_q_valid", {7'b0, dout_q_valid}, 8'h00);

        // Spot table; the combinational output tracks in while reset is held.
        for (int i = 0; i < 10; i++) begin
            din = spot[i].din;
            #1;
            check($sformatf("spot_%02h", spot[i].din), dout, spot[i].exp);
        end
        check("reset_hold_out_q", dout_q, 8'h00);
        check("reset_hold_out_q_valid", {7'b0, dout_q_valid}, 8'h00);

        // Exhaustive combinational sweep against the reference model.
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++) begin
            din = 8'(i);
            #5;
            check($sformatf("sweep_%02h", i), dout, sbox_ref(8'(i)));
        end

        // Registered latency after a fresh reset.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rereset_out_q", dout_q, 8'h00);
        @(negedge clk);
        rst_n     = 1'b1;
        din       = 8'h53;
        din_valid = 1'b1;
        tick();
        check("lat_edge1_out_q", dout_q, 8'hED);
        check("lat_edge1_valid", {7'b0, dout_q_valid}, 8'h01);
        din       = 8'h01;
        din_valid = 1'b0;
        tick();
        check("lat_edge2_out_q", dout_q, 8'h7C);
        check("lat_edge2_valid", {7'b0, dout_q_valid}, 8'h00);

        // Asynchronous reset between edges drops the held value.
        din       = 8'hFF;
        din_valid = 1'b1;
        tick();
        check("pre_arst_out_q", dout_q, 8'h16);
        check("pre_arst_valid", {7'b0, dout_q_valid}, 8'h01);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_out_q", dout_q, 8'h00);
        check("arst_valid", {7'b0, dout_q_valid}, 8'h00);
        check("arst_out_comb", dout, 8'h16);
        repeat (3) tick();
        check("arst_hold_out_q", dout_q, 8'h00);
        check("arst_hold_valid", {7'b0, dout_q_valid}, 8'h00);
        check("arst_hold_out_comb", dout, 8'h16);

        // Reset release: first capture on the next rising edge.
        @(negedge clk);
        din       = 8'h10;
        din_valid = 1'b1;
        rst_n     = 1'b1;
        tick();
        check("release_out_q", dout_q, 8'hCA);
        check("release_valid", {7'b0, dout_q_valid}, 8'h01);

        // Back-to-back streaming with random bytes, valid held high.
        for (int i = 0; i < 256; i++) begin
            cur       = 8'($urandom_range(0, 255));
            din       = cur;
            din_valid = 1'b1;
            tick();
            check($sformatf("stream_%0d_out_q", i), dout_q, sbox_ref(cur));
            check($sformatf("stream_%0d_valid", i), {7'b0, dout_q_valid}, 8'h01);
        end

        // Random bytes with random valid: out_q captures regardless of valid.
        for (int i = 0; i < 64; i++) begin
            cur       = 8'($urandom_range(0, 255));
            cur_v     = 1'($urandom_range(0, 1));
            din       = cur;
            din_valid = cur_v;
            #2;
            check($sformatf("rand_%0d_out", i), dout, sbox_ref(cur));
            tick();
            check($sformatf("rand_%0d_out_q", i), dout_q, sbox_ref(cur));
            check($sformatf("rand_%0d_valid", i), {7'b0, dout_q_valid}, {7'b0, cur_v});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/aes_sbox_gf24.md
Name: aes_sbox_gf24

Overview:
- AES forward S-box (FIPS-197 SubBytes) for one byte, built as a composite-field GF((2^4)^2) datapath rather than a 256-entry lookup table.
- Sits inside an AES round's SubBytes/key-expansion logic as a reusable leaf.
- Provides a combinational result and a registered, reset-qualified copy for pipelined users.

Parameters:
- None. Data width is fixed at 8 bits.

Ports:
- clk      input   1  rising-edge clock for the output register
- rst_n    input   1  asynchronous active-low reset
- in       input   8  byte to substitute
- in_valid input   1  qualifies in for the registered path
- out      output  8  combinational S(in), no clock dependency
- out_q    output  8  registered S(in), one cycle after capture
- out_q_valid output 1  registered in_valid

Behaviour:
- One clock; reset is asynchronous and active-low.
- Combinational path:
  - out = AES S-box(in) for all 256 values, with no latency.
  - out settles within the same evaluation in which in changes.
  - out does not depend on clk, rst_n or in_valid.
- Datapath stages, all combinational:
  1. Isomorphic map delta: GF(2^8) (poly x^8+x^4+x^3+x+1) into GF((2^4)^2).
  2. Split the mapped byte into high nibble h and low nibble l.
  3. Compute the GF(2^4) inverse d^-1 of d = (h+l)*l + lambda*h^2. Field poly x^4+x+1; ground extension y^2+y+lambda, lambda = 0xC.
  4. Form h' = h*d^-1 and l' = (h+l)*d^-1.
  5. Inverse map delta^-1 back to GF(2^8).
  6. AES affine transform: b'_i = b_i ^ b_(i+4) ^ b_(i+5) ^ b_(i+6) ^ b_(i+7) ^ c_i, with c = 0x63 and indices mod 8.
- Datapath implementation rules:
  - Any valid isomorphism pair delta/delta^-1 consistent with the chosen polynomials is acceptable.
  - Sub-blocks required: GF(2^4) multiplier, squarer, lambda-constant multiplier, GF(2^4) inverter (XOR/AND logic or 16-entry function), delta and delta^-1 matrices, affine.
  - No 256-entry table is permitted.
- Inversion of zero: 0x00 maps to inverse 0x00 (d = 0 gives d^-1 = 0), so S(0x00) = 0x63.
- Registered path:
  - On each rising clk: out_q <= S(in) and out_q_valid <= in_valid.
  - out_q captures S(in) every cycle, regardless of in_valid; out_q_valid marks meaningful data.
  - Latency is exactly 1 cycle.
- Reset:
  - rst_n low immediately forces out_q = 0x00 and out_q_valid = 0, independent of clk.
  - Both hold at those values while rst_n is low.
  - The first capture happens on the first rising clk after rst_n deasserts.
  - Reset mid-stream drops any in-flight value.
  - The combinational out keeps tracking in during reset.
- No internal state other than the two output registers.
- Simultaneous in change and clk edge: the registered value is S(in) as sampled at the edge, i.e. standard setup/hold.

Test Plan:
- Exhaustive sweep:
  - Stimulus: in = 0x00..0xFF, stepping every 5 time units, rst_n held high.
  - Check: out matches the FIPS-197 table for all 256 inputs.
  - Spot values: 00->63, 01->7C, 10->CA, 52->00, 53->ED, 63->FB, C9->DD, FF->16.
- Zero-inverse corner: in = 0x00 -> out = 0x63, and in = 0x52 -> out = 0x00 (the output-zero case).
- Registered latency:
  - Stimulus: after reset, drive in = 0x53 with in_valid = 1 for one cycle, then in = 0x01 with in_valid = 0.
  - Check: out_q = 0xED with out_q_valid = 1 after edge 1; out_q = 0x7C with out_q_valid = 0 after edge 2.
- Asynchronous reset:
  - Stimulus: with out_q = 0x16 (in = 0xFF), assert rst_n = 0 between clock edges.
  - Check: out_q = 0x00 and out_q_valid = 0 immediately, with no clk edge needed; they stay there while clk toggles.
  - Check: out keeps showing 0x16.
- Reset release: deassert rst_n with in = 0x10 and in_valid = 1 -> next rising edge gives out_q = 0xCA, out_q_valid = 1.
- Back-to-back streaming: one new in per cycle with in_valid = 1 for 256 cycles -> out_q equals S(previous-cycle in) on every cycle and out_q_valid stays 1.
